// File: rtl/mm2s_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mm2s_cmd_sequencer_pkg
// Shared definitions for the MM2S datamover command sequencer:
//   - FSM state encoding (state_t)
//   - bit positions of the fields inside the 72-bit datamover command
//   - default maximum bytes-to-transfer per command
// -----------------------------------------------------------------------------
package mm2s_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Datamover MM2S command layout
    localparam int CMD_W     = 72;
    localparam int BTT_LSB   = 0;
    localparam int BTT_MSB   = 22;
    localparam int BTT_W     = BTT_MSB - BTT_LSB + 1;
    localparam int TYPE_BIT  = 23;   // 1 = INCR burst
    localparam int EOF_BIT   = 30;
    localparam int SADDR_LSB = 32;
    localparam int TAG_LSB   = 64;

    localparam int PACKET_SIZE_DEF = 4096;

endpackage

// File: rtl/mm2s_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// mm2s_cmd_sequencer
// Splits a (base_addr, cap_size) region into datamover MM2S commands of at
// most PACKET_SIZE bytes each and issues them over a valid/ready stream.
//
// Optional feature macro: MM2S_CMD_LOOP_EN
//   defined     : at end of a pass the region is reloaded and issued again,
//                 forever, until read_reset.
//   not defined : a single pass, then DONE waits for read_start to drop.
//
// Ports
//   axis_st_clk    in   clock
//   axis_st_rstb   in   asynchronous active-low reset
//   read_start     in   level; a rising edge in IDLE arms a run
//   read_reset     in   synchronous abort/clear, highest priority
//   base_addr      in   [31:0] byte start address, sampled in LOAD
//   cap_size       in   [31:0] bytes per pass, sampled in LOAD
//   m_axis_tdata   out  [71:0] datamover command
//   m_axis_tvalid  out  command valid (high exactly in ISSUE)
//   m_axis_tready  in   command ready
//   busy           out  high whenever the FSM is not IDLE
//   cmd_count      out  [31:0] accepted commands
//   pass_count     out  [7:0] completed passes (wraps)
//   fsm_state      out  current FSM state, for debug/observation
//
// Handshake: a command transfers on a rising clock edge where tvalid and
// tready are both high; while tvalid is high and tready low the command word
// is held unchanged, and tvalid never drops without a transfer except on
// read_reset or axis_st_rstb.
// -----------------------------------------------------------------------------
module mm2s_cmd_sequencer
    import mm2s_cmd_sequencer_pkg::*;
#(
    parameter int PACKET_SIZE = PACKET_SIZE_DEF,
    parameter int TAG_W       = 4
) (
    input  logic              axis_st_clk,
    input  logic              axis_st_rstb,
    input  logic              read_start,
    input  logic              read_reset,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       cap_size,
    output logic [CMD_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic [31:0]       cmd_count,
    output logic [7:0]        pass_count,
    output state_t            fsm_state
);

    state_t            state;
    state_t            state_next;

    logic              start_q;     // read_start history
    logic              hist_ok;     // history valid; blocks a false edge right after reset
    logic              start_edge;

    logic [31:0]       addr;
    logic [31:0]       rem;
    logic [TAG_W-1:0]  tag;
`ifdef MM2S_CMD_LOOP_EN
    // Kept only for the end-of-pass reload in loop mode.
    logic [31:0]       base_q;
    logic [31:0]       size_q;
`endif

    logic [BTT_W-1:0]  btt;
    logic              is_eof;
    logic [CMD_W-1:0]  cmd;

    // A level that is already high when reset releases must not look like an
    // edge: hist_ok stays low for the first clock after reset.
    assign start_edge = read_start & ~start_q & hist_ok;

    assign btt    = (rem > 32'(PACKET_SIZE)) ? BTT_W'(PACKET_SIZE) : rem[BTT_W-1:0];
    assign is_eof = (rem <= 32'(PACKET_SIZE));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
        if (!axis_st_rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (read_reset) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_edge) state_next = ST_LOAD;
                ST_LOAD:  state_next = (cap_size == 32'd0) ? ST_IDLE : ST_ISSUE;
                ST_ISSUE: if (m_axis_tready) state_next = ST_NEXT;
                ST_NEXT: begin
                    if (rem != 32'd0) begin
                        state_next = ST_ISSUE;
                    end else begin
`ifdef MM2S_CMD_LOOP_EN
                        state_next = ST_ISSUE;
`else
                        state_next = ST_DONE;
`endif
                    end
                end
                ST_DONE:  if (!read_start) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
        if (!axis_st_rstb) begin
            start_q    <= 1'b0;
            hist_ok    <= 1'b0;
            addr       <= '0;
            rem        <= '0;
            tag        <= '0;
            cmd_count  <= '0;
            pass_count <= '0;
`ifdef MM2S_CMD_LOOP_EN
            base_q     <= '0;
            size_q     <= '0;
`endif
        end else begin
            start_q <= read_start;
            hist_ok <= 1'b1;
            if (read_reset) begin
                tag        <= '0;
                cmd_count  <= '0;
                pass_count <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        addr   <= base_addr;
                        rem    <= cap_size;
`ifdef MM2S_CMD_LOOP_EN
                        base_q <= base_addr;
                        size_q <= cap_size;
`endif
                    end
                    ST_ISSUE: begin
                        if (m_axis_tready) begin
                            cmd_count <= cmd_count + 32'd1;
                            tag       <= tag + TAG_W'(1);
                            addr      <= addr + 32'(btt);
                            rem       <= rem - 32'(btt);
                        end
                    end
                    ST_NEXT: begin
                        if (rem == 32'd0) begin
                            pass_count <= pass_count + 8'd1;
`ifdef MM2S_CMD_LOOP_EN
                            addr       <= base_q;
                            rem        <= size_q;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Command word; forced to zero outside ISSUE so the bus is quiet
    // in reset and idle. Its sources only change on a handshake, which
    // keeps it stable during backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        cmd                          = '0;
        cmd[BTT_MSB:BTT_LSB]         = btt;
        cmd[TYPE_BIT]                = 1'b1;
        cmd[EOF_BIT]                 = is_eof;
        cmd[SADDR_LSB +: 32]         = addr;
        cmd[TAG_LSB +: TAG_W]        = tag;
    end

    assign m_axis_tvalid = (state == ST_ISSUE);
    assign m_axis_tdata  = m_axis_tvalid ? cmd : '0;
    assign busy          = (state != ST_IDLE);
    assign fsm_state     = state;

endmodule

// File: tb/tb_mm2s_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mm2s_cmd_sequencer
// Directed self-checking bench for mm2s_cmd_sequencer. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge.
// Builds with or without MM2S_CMD_LOOP_EN; the loop scenario replaces the
// single-pass scenario when the macro is defined.
// -----------------------------------------------------------------------------
module tb_mm2s_cmd_sequencer;
    import mm2s_cmd_sequencer_pkg::*;

    logic         clk;
    logic         rstb;
    logic         read_start;
    logic         read_reset;
    logic [31:0]  base_addr;
    logic [31:0]  cap_size;
    logic [71:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         busy;
    logic [31:0]  cmd_count;
    logic [7:0]   pass_count;
    state_t       fsm_state;

    int checks = 0;
    int errors = 0;

    // captured handshakes
    logic [71:0]  cap_q[$];
    logic [31:0]  cap_pass_q[$];
    logic [31:0]  cap_cnt_q[$];
    logic [71:0]  exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    mm2s_cmd_sequencer #(.PACKET_SIZE(4096), .TAG_W(4)) dut (
        .axis_st_clk   (clk),
        .axis_st_rstb  (rstb),
        .read_start    (read_start),
        .read_reset    (read_reset),
        .base_addr     (base_addr),
        .cap_size      (cap_size),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .cmd_count     (cmd_count),
        .pass_count    (pass_count),
        .fsm_state     (fsm_state)
    );

    // Expected command word: {pad, tag, addr, 0, eof, 000000, INCR, btt}
    function automatic logic [71:0] cmd_word(input logic [22:0] btt, input logic eof,
                                             input logic [31:0] addr, input logic [3:0] tag);
        return {4'b0, tag, addr, 1'b0, eof, 6'b0, 1'b1, btt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rstb          = 1'b0;
        read_start    = 1'b0;
        read_reset    = 1'b0;
        m_axis_tready = 1'b0;
        base_addr     = '0;
        cap_size      = '0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Record every handshake (seen at negedge before the accepting posedge).
    task automatic collect(input int n, input int budget, output int got);
        cap_q.delete();
        cap_pass_q.delete();
        cap_cnt_q.delete();
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                cap_q.push_back(m_axis_tdata);
                cap_pass_q.push_back(32'(pass_count));
                cap_cnt_q.push_back(cmd_count);
                got++;
            end
        end
    endtask

    task automatic wait_tvalid(input int budget);
        for (int c = 0; c < budget && !m_axis_tvalid; c++) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstb = 1'b0; read_start = 1'b1; read_reset = 1'b0;
        m_axis_tready = 1'b0; base_addr = 32'h0000_1000; cap_size = 32'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 72'h0 || busy !== 1'b0 ||
            cmd_count !== 32'd0 || pass_count !== 8'd0 || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: tvalid=%b tdata=%h busy=%b cmd=%0d pass=%0d state=%0d, required all zero/IDLE",
                     m_axis_tvalid, m_axis_tdata, busy, cmd_count, pass_count, fsm_state);
        end
        rstb = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL no_arm_on_release: busy=%b state=%0d, required busy=0 IDLE", busy, fsm_state);
        end
        read_start = 1'b0;
        @(negedge clk);
        read_start = 1'b1;
        wait_tvalid(10);
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_run_tvalid: tvalid=%b required 1", m_axis_tvalid);
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 72'h0 || busy !== 1'b0 || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL async_reset: tvalid=%b tdata=%h busy=%b state=%0d, required 0/0/0/IDLE",
                     m_axis_tvalid, m_axis_tdata, busy, fsm_state);
        end
        do_reset();
    endtask

`ifndef MM2S_CMD_LOOP_EN
    task automatic test_single_pass();
        int got;
        do_reset();
        base_addr = 32'h1000_0000; cap_size = 32'd10000; m_axis_tready = 1'b1;
        read_start = 1'b1;
        exp_q.delete();
        exp_q.push_back(cmd_word(23'd4096, 1'b0, 32'h1000_0000, 4'd0));
        exp_q.push_back(cmd_word(23'd4096, 1'b0, 32'h1000_1000, 4'd1));
        exp_q.push_back(cmd_word(23'd1808, 1'b1, 32'h1000_2000, 4'd2));
        collect(3, 60, got);
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL single_cmd_total: got %0d commands, required 3", got);
        end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i] || cap_cnt_q[i] !== 32'(i) || cap_pass_q[i] !== 32'd0) begin
                errors++;
                $display("FAIL single_cmd%0d: tdata=%h cnt=%0d pass=%0d, required %h cnt=%0d pass=0",
                         i, cap_q[i], cap_cnt_q[i], cap_pass_q[i], exp_q[i], i);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fsm_state !== ST_DONE || pass_count !== 8'd1 || cmd_count !== 32'd3 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: state=%0d pass=%0d cmd=%0d tvalid=%b, required DONE 1 3 0",
                     fsm_state, pass_count, cmd_count, m_axis_tvalid);
        end
        read_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fsm_state !== ST_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_to_idle: state=%0d busy=%b, required IDLE 0", fsm_state, busy);
        end
    endtask
`else
    task automatic test_loop();
        int got;
        do_reset();
        base_addr = 32'h5000_0000; cap_size = 32'd8192; m_axis_tready = 1'b1;
        read_start = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(cmd_word(23'd4096, 1'(i % 2),
                                     32'h5000_0000 + 32'(i % 2) * 32'd4096, 4'(i % 16)));
        end
        collect(18, 120, got);
        checks++;
        if (got !== 18) begin
            errors++;
            $display("FAIL loop_cmd_total: got %0d commands, required 18", got);
        end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i] || cap_cnt_q[i] !== 32'(i) || cap_pass_q[i] !== 32'(i / 2)) begin
                errors++;
                $display("FAIL loop_cmd%0d: tdata=%h cnt=%0d pass=%0d, required %h cnt=%0d pass=%0d",
                         i, cap_q[i], cap_cnt_q[i], cap_pass_q[i], exp_q[i], i, i / 2);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pass_count !== 8'd9 || cmd_count !== 32'd18 || fsm_state !== ST_ISSUE) begin
            errors++;
            $display("FAIL loop_counts: pass=%0d cmd=%0d state=%0d, required 9 18 ISSUE",
                     pass_count, cmd_count, fsm_state);
        end
        read_start = 1'b0;
        do_reset();
    endtask
`endif

    task automatic test_zero_size();
        int busy_cycles;
        int valid_cycles;
        do_reset();
        base_addr = 32'h0800_0000; cap_size = 32'd0; m_axis_tready = 1'b1;
        read_start = 1'b1;
        busy_cycles = 0;
        valid_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (m_axis_tvalid) valid_cycles++;
        end
        checks++;
        if (busy_cycles !== 1 || valid_cycles !== 0) begin
            errors++;
            $display("FAIL zero_size: busy_cycles=%0d tvalid_cycles=%0d, required 1 and 0", busy_cycles, valid_cycles);
        end
        checks++;
        if (fsm_state !== ST_IDLE || cmd_count !== 32'd0) begin
            errors++;
            $display("FAIL zero_size_end: state=%0d cmd=%0d, required IDLE 0", fsm_state, cmd_count);
        end
        read_start = 1'b0;
    endtask

    task automatic test_stall();
        logic [71:0] snap;
        int unstable;
        do_reset();
        base_addr = 32'h2000_0000; cap_size = 32'd5000; m_axis_tready = 1'b0;
        read_start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_axis_tvalid !== 1'b0 || fsm_state !== ST_LOAD) begin
            errors++;
            $display("FAIL latency_load: busy=%b tvalid=%b state=%0d, required 1 0 LOAD", busy, m_axis_tvalid, fsm_state);
        end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== cmd_word(23'd4096, 1'b0, 32'h2000_0000, 4'd0)) begin
            errors++;
            $display("FAIL first_cmd: tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata,
                     cmd_word(23'd4096, 1'b0, 32'h2000_0000, 4'd0));
        end
        snap = m_axis_tdata;
        base_addr = 32'hDEAD_0000;
        cap_size  = 32'd7;
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_axis_tdata !== snap || m_axis_tvalid !== 1'b1 || cmd_count !== 32'd0) unstable++;
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable cycles, required 0", unstable);
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_count !== 32'd1 || m_axis_tvalid !== 1'b0 || fsm_state !== ST_NEXT) begin
            errors++;
            $display("FAIL stall_accept: cmd=%0d tvalid=%b state=%0d, required 1 0 NEXT", cmd_count, m_axis_tvalid, fsm_state);
        end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== cmd_word(23'd904, 1'b1, 32'h2000_1000, 4'd1)) begin
            errors++;
            $display("FAIL stall_second_cmd: tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata,
                     cmd_word(23'd904, 1'b1, 32'h2000_1000, 4'd1));
        end
        read_start = 1'b0;
    endtask

    task automatic test_addr_wrap();
        int got;
        do_reset();
        base_addr = 32'hFFFF_F000; cap_size = 32'd8192; m_axis_tready = 1'b1;
        read_start = 1'b1;
        collect(2, 40, got);
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL wrap_total: got %0d commands, required 2", got);
        end else begin
            checks++;
            if (cap_q[0] !== cmd_word(23'd4096, 1'b0, 32'hFFFF_F000, 4'd0)) begin
                errors++;
                $display("FAIL wrap_cmd0: tdata=%h required %h", cap_q[0], cmd_word(23'd4096, 1'b0, 32'hFFFF_F000, 4'd0));
            end
            checks++;
            if (cap_q[1] !== cmd_word(23'd4096, 1'b1, 32'h0000_0000, 4'd1)) begin
                errors++;
                $display("FAIL wrap_cmd1: tdata=%h required %h", cap_q[1], cmd_word(23'd4096, 1'b1, 32'h0000_0000, 4'd1));
            end
        end
        read_start = 1'b0;
    endtask

    task automatic test_read_reset();
        do_reset();
        base_addr = 32'h3000_0000; cap_size = 32'd8192; m_axis_tready = 1'b1;
        read_start = 1'b1;
        for (int c = 0; c < 20 && cmd_count != 32'd1; c++) @(negedge clk);
        m_axis_tready = 1'b0;
        @(negedge clk);
        wait_tvalid(10);
        checks++;
        if (m_axis_tvalid !== 1'b1 || cmd_count !== 32'd1) begin
            errors++;
            $display("FAIL rr_setup: tvalid=%b cmd=%0d, required 1 1", m_axis_tvalid, cmd_count);
        end
        read_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || fsm_state !== ST_IDLE || busy !== 1'b0 ||
            cmd_count !== 32'd0 || pass_count !== 8'd0) begin
            errors++;
            $display("FAIL rr_clear: tvalid=%b state=%0d busy=%b cmd=%0d pass=%0d, required 0 IDLE 0 0 0",
                     m_axis_tvalid, fsm_state, busy, cmd_count, pass_count);
        end
        read_reset = 1'b0;
        read_start = 1'b0;
        base_addr  = 32'h4000_0000;
        cap_size   = 32'd100;
        @(negedge clk);
        read_start = 1'b1;
        wait_tvalid(10);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== cmd_word(23'd100, 1'b1, 32'h4000_0000, 4'd0)) begin
            errors++;
            $display("FAIL rr_restart: tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata,
                     cmd_word(23'd100, 1'b1, 32'h4000_0000, 4'd0));
        end
        read_start = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstb = 1'b0; read_start = 1'b0; read_reset = 1'b0;
        m_axis_tready = 1'b0; base_addr = '0; cap_size = '0;
        test_reset();
`ifdef MM2S_CMD_LOOP_EN
        test_loop();
`else
        test_single_pass();
`endif
        test_zero_size();
        test_stall();
        test_addr_wrap();
        test_read_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
